// File: rtl/alarma_ctrl.sv
// alarma_ctrl: keypad-armed home alarm with exit/entry delays, zone latch and horn drive.
// Optional ALARMA_CHIRP_EN: horn chirps 1 tick on / 1 tick off during EXIT and ENTRY.
module alarma_ctrl #(
   parameter int          TICK_DIV = 1000,
   parameter int          EXIT_T   = 30,
   parameter int          ENTRY_T  = 15,
   parameter int          ALARM_T  = 180,
   parameter logic [15:0] CODE     = 16'h1234
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] Digit,
   input  logic       DigitValid,
   input  logic       P,
   input  logic       Co,
   input  logic       Ca,
   input  logic       G,
   input  logic       V,
   input  logic       Pa,
   output logic       Bocina,
   output logic       Armado,
   output logic [2:0] Estado,
   output logic [5:0] Zona
);
   typedef enum logic [2:0] {DISARMED = 3'd0, EXIT = 3'd1, ARMED = 3'd2, ENTRY = 3'd3, ALARM = 3'd4} state_t;
`ifdef ALARMA_CHIRP_EN
   localparam bit CHIRP = 1'b1;
`else
   localparam bit CHIRP = 1'b0;
`endif
   localparam int MAXT = (EXIT_T > ENTRY_T) ? ((EXIT_T > ALARM_T) ? EXIT_T : ALARM_T)
                                            : ((ENTRY_T > ALARM_T) ? ENTRY_T : ALARM_T);
   localparam int TW = $clog2(MAXT + 1);
   localparam int PW = $clog2(TICK_DIV);

   state_t          state, nstate;
   logic [PW-1:0]   pre;
   logic [TW-1:0]   timer, load;
   logic [1:0]      cnt, bad;
   logic [15:0]     sh, word;
   logic            par, par_n, tick, timeout, full, code_ok, code_bad, watched, changed, bad_trip;
   logic [5:0]      zona_n;
   logic            armado_n, bocina_n;

   assign Estado = state;

   // next state by priority: panic, code, third bad code, instant zones, door, timeout
   always_comb begin
      word     = {sh[11:0], Digit};
      full     = DigitValid && cnt == 2'd3;
      code_ok  = full && word == CODE;
      code_bad = full && !code_ok;
      tick     = pre == PW'(TICK_DIV - 1);
      timeout  = tick && timer == TW'(1);
      watched  = state == ARMED || state == ENTRY || state == ALARM;
      bad_trip = code_bad && watched && bad == 2'd2;
      nstate   = state;
      if (Pa)
         nstate = ALARM;
      else if (code_ok)
         nstate = (state == DISARMED) ? EXIT : DISARMED;
      else if (bad_trip)
         nstate = ALARM;
      else if ((state == ARMED || state == ENTRY) && (Co || Ca || G || V))
         nstate = ALARM;
      else if (state == ARMED && P)
         nstate = ENTRY;
      else if (timeout)
         nstate = (state == EXIT) ? ARMED : (state == ENTRY) ? ALARM : (state == ALARM) ? ARMED : state;
      changed  = nstate != state;
      load     = (nstate == EXIT) ? TW'(EXIT_T) : (nstate == ENTRY) ? TW'(ENTRY_T) :
                 (nstate == ALARM) ? TW'(ALARM_T) : '0;
      par_n    = changed ? 1'b0 : (tick ? ~par : par);
      zona_n   = (nstate == DISARMED || nstate == EXIT) ? 6'd0 :
                 Zona | {Pa, watched ? {V, G, Ca, Co, P} : 5'd0};
      armado_n = nstate == ARMED || nstate == ENTRY || nstate == ALARM;
      bocina_n = nstate == ALARM || (CHIRP && (nstate == EXIT || nstate == ENTRY) && !par_n);
   end

   // state, timers, keypad, bad-code count and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= DISARMED;
         pre    <= '0;
         timer  <= '0;
         par    <= 1'b0;
         cnt    <= 2'd0;
         sh     <= 16'd0;
         bad    <= 2'd0;
         Zona   <= 6'd0;
         Armado <= 1'b0;
         Bocina <= 1'b0;
      end else begin
         state  <= nstate;
         pre    <= (changed || tick) ? '0 : pre + PW'(1);
         timer  <= changed ? load : (tick && timer != '0) ? timer - TW'(1) : timer;
         par    <= par_n;
         cnt    <= changed ? 2'd0 : DigitValid ? cnt + 2'd1 : cnt;
         sh     <= DigitValid ? word : sh;
         bad    <= (code_ok || bad_trip) ? 2'd0 : (code_bad && watched) ? bad + 2'd1 : bad;
         Zona   <= zona_n;
         Armado <= armado_n;
         Bocina <= bocina_n;
      end
   end
endmodule

// File: tb/tb_alarma_ctrl.sv
// tb_alarma_ctrl: directed self-checking bench for alarma_ctrl with small timing parameters.
module tb_alarma_ctrl;
`ifdef ALARMA_CHIRP_EN
   localparam bit CHIRP = 1'b1;
`else
   localparam bit CHIRP = 1'b0;
`endif
   logic       clk = 1'b0, rst_n = 1'b0;
   logic [3:0] digit = 4'd0;
   logic       digit_valid = 1'b0, p = 1'b0, co = 1'b0, ca = 1'b0, g = 1'b0, v = 1'b0, pa = 1'b0;
   logic       bocina, armado;
   logic [2:0] estado;
   logic [5:0] zona;
   int         n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   alarma_ctrl #(.TICK_DIV(4), .EXIT_T(3), .ENTRY_T(2), .ALARM_T(5), .CODE(16'h1234)) dut (
      .clk(clk), .rst_n(rst_n), .Digit(digit), .DigitValid(digit_valid),
      .P(p), .Co(co), .Ca(ca), .G(g), .V(v), .Pa(pa),
      .Bocina(bocina), .Armado(armado), .Estado(estado), .Zona(zona)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic key(input logic [3:0] d);
      digit = d;
      digit_valid = 1'b1;
      step();
      digit_valid = 1'b0;
   endtask

   task automatic code(input logic [15:0] c);
      for (int i = 3; i >= 0; i--) key(c[i*4 +: 4]);
   endtask

   task automatic arm();
      code(16'h1234);
      step(12);
   endtask

   initial begin
      step(2);
      check("rst estado", estado, 0);
      check("rst armado", armado, 0);
      check("rst bocina", bocina, 0);
      check("rst zona", zona, 0);
      rst_n = 1'b1;
      code(16'h1234);
      for (int k = 0; k < 12; k++) begin
         check("exit estado", estado, 1);
         check("exit bocina", bocina, 16'(CHIRP && ((k / 4) % 2 == 0)));
         step();
      end
      check("armed estado", estado, 2);
      check("armed armado", armado, 1);
      check("armed bocina", bocina, 0);
      p = 1'b1;
      step();
      p = 1'b0;
      check("entry estado", estado, 3);
      check("entry zona", zona, 6'b000001);
      check("entry bocina", bocina, 16'(CHIRP));
      step(7);
      check("entry end estado", estado, 3);
      step();
      check("alarm estado", estado, 4);
      check("alarm bocina", bocina, 1);
      step(19);
      check("alarm end estado", estado, 4);
      step();
      check("rearm estado", estado, 2);
      check("rearm bocina", bocina, 0);
      check("rearm zona", zona, 6'b000001);
      code(16'h1234);
      check("disarm estado", estado, 0);
      check("disarm zona", zona, 0);
      arm();
      g = 1'b1;
      step();
      g = 1'b0;
      check("g estado", estado, 4);
      check("g zona", zona, 6'b001000);
      code(16'h1234);
      check("g off estado", estado, 0);
      check("g off zona", zona, 0);
      check("g off bocina", bocina, 0);
      check("g off armado", armado, 0);
      arm();
      code(16'h1111);
      check("bad1 estado", estado, 2);
      code(16'h1111);
      check("bad2 estado", estado, 2);
      code(16'h1111);
      check("bad3 estado", estado, 4);
      check("bad3 zona", zona, 0);
      step(20);
      check("bad rearm estado", estado, 2);
      p = 1'b1;
      step();
      p = 1'b0;
      code(16'h1111);
      check("entry bad estado", estado, 3);
      code(16'h1234);
      check("entry ok estado", estado, 0);
      arm();
      code(16'h1111);
      code(16'h1111);
      check("bad cleared estado", estado, 2);
      code(16'h1111);
      check("bad again estado", estado, 4);
      code(16'h1234);
      check("bad again off", estado, 0);
      key(4'd1);
      key(4'd2);
      key(4'd3);
      digit = 4'd4;
      digit_valid = 1'b1;
      pa = 1'b1;
      step();
      digit_valid = 1'b0;
      pa = 1'b0;
      check("panic estado", estado, 4);
      check("panic zona", zona, 6'b100000);
      code(16'h1234);
      check("panic off", estado, 0);
      code(16'h1234);
      co = 1'b1;
      step();
      co = 1'b0;
      check("exit co estado", estado, 1);
      check("exit co zona", zona, 0);
      step(11);
      check("co armed estado", estado, 2);
      p = 1'b1;
      step();
      p = 1'b0;
      key(4'd1);
      key(4'd2);
      check("pre rst estado", estado, 3);
      rst_n = 1'b0;
      step();
      check("mid rst estado", estado, 0);
      check("mid rst armado", armado, 0);
      check("mid rst bocina", bocina, 0);
      check("mid rst zona", zona, 0);
      rst_n = 1'b1;
      code(16'h1234);
      check("post rst code", estado, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/alarma_ctrl.md
Name: alarma_ctrl

Overview:
Sequential home-alarm controller built around the horn logic. It arms and disarms from a 4-digit keypad code, runs timed exit and entry delays, and latches which sensor caused an alarm. It drives the horn (Bocina) with a timed alarm period. It sits between the keypad/sensor front end (synchronizers upstream) and the horn driver.

Parameters:
TICK_DIV, 1000, clk cycles per timer tick (>=2)
EXIT_T, 30, exit delay in ticks (>=1)
ENTRY_T, 15, entry delay in ticks (>=1)
ALARM_T, 180, horn-on period in ticks before auto re-arm (>=1)
CODE, 16'h1234, arm/disarm code as 4 nibbles, first-entered digit in [15:12]

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
Digit  in  4  keypad digit value
DigitValid  in  1  one-cycle strobe, Digit valid
P  in  1  door sensor (delayed zone)
Co  in  1  sensor, instant zone
Ca  in  1  sensor, instant zone
G  in  1  sensor, instant zone
V  in  1  sensor, instant zone
Pa  in  1  panic button, 24h zone
Bocina  out  1  horn drive
Armado  out  1  1 in ARMED, ENTRY, ALARM
Estado  out  3  state code
Zona  out  6  latched trigger sources {Pa,V,G,Ca,Co,P}

Behaviour:
- One clock domain; reset is synchronous, active-low (rst_n sampled on rising clk). All inputs are synchronous to clk.
- Reset: state DISARMED, Bocina=0, Armado=0, Estado=0, Zona=0. Digit count, bad-attempt count, timer, and prescaler = 0.
- States and Estado encoding: DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4. Estado, Armado, and Bocina are registered and decoded from the state register.
- Prescaler: counts 0..TICK_DIV-1 and emits a tick on wrap. It is cleared on every state change. The state timer loads N (EXIT_T/ENTRY_T/ALARM_T) on state entry and decrements on each tick. At 0 the timeout fires, so the state register changes exactly N*TICK_DIV cycles after it entered the state.
- Keypad: a 2-bit digit count and a 16-bit shift register (new digit shifts into [3:0]). On the DigitValid that supplies the 4th digit, the assembled word is compared to CODE in the same cycle. The resulting state change is visible after that edge. The count returns to 0. The count also clears on any state change. Any nibble value is accepted.
- Transitions, priority high→low when simultaneous:
  1. Pa=1 in any state → ALARM; Zona[5] set.
  2. Correct code: DISARMED→EXIT; EXIT/ARMED/ENTRY/ALARM→DISARMED. A correct code clears the bad count.
  3. Wrong code in ARMED/ENTRY/ALARM → bad count +1; the 3rd consecutive wrong code → ALARM (no Zona bit), and the bad count clears. Wrong codes in DISARMED/EXIT are ignored.
  4. ARMED and any of Co/Ca/G/V=1 → ALARM, and ENTRY likewise → ALARM; the matching Zona bits are set.
  5. ARMED and P=1 → ENTRY; Zona[0] set.
  6. Timeout: EXIT→ARMED, ENTRY→ALARM, ALARM→ARMED.
- Sensors other than Pa are ignored in DISARMED and EXIT. In ALARM, any active sensor ORs its bit into Zona, and re-entry to ALARM from ALARM does not restart the timer.
- Zona clears on entry to DISARMED or EXIT. It otherwise holds through ALARM→ARMED re-arm.
- Bocina=1 for the whole ALARM state, else 0 (see optional feature).
- Reset asserted mid-delay or mid-alarm returns to the reset values on the next edge; partial codes are discarded.

Optional Feature:
ALARMA_CHIRP_EN: when defined, Bocina also chirps during EXIT and ENTRY: 1 on even tick counts since state entry, 0 on odd (1 tick on / 1 tick off, starting at 1 on the entry cycle). When undefined, Bocina is 0 outside ALARM. State and timing are identical either way.

Test Plan:
- Params TICK_DIV=4, EXIT_T=3, ENTRY_T=2, ALARM_T=5, CODE=16'h1234 for all tests.
- Reset, then enter 1,2,3,4 → Estado=1 after the 4th digit edge. Exactly 12 cycles later Estado=2, Armado=1; Bocina=0 throughout with the macro off.
- ARMED, P pulse → Estado=3, Zona=6'b000001. No code is entered → Estado=4, Bocina=1 after 8 cycles. 20 cycles later → Estado=2, Bocina=0, Zona held.
- ARMED, G=1 → Estado=4, Zona=6'b001000. Then 1,2,3,4 → Estado=0, Zona=0, Bocina=0.
- ARMED, three codes 1,1,1,1 → Estado=4 after the 3rd code's last digit, Zona=0. One wrong code then the correct code in ENTRY → DISARMED and bad count cleared.
- DISARMED, Pa=1 in the same cycle as the 4th digit of a correct code → Estado=4, Zona[5]=1 (panic wins). In EXIT, Co=1 → no change.
- ALARMA_CHIRP_EN defined: in EXIT, Bocina toggles every 4 cycles, starting at 1. Assert rst_n=0 mid-ENTRY → all outputs 0 next edge.
